// File: rtl/unidade_controle_jogadas.sv
// unidade_controle_jogadas: Moore FSM that sequences the multi-round memory-game datapath.
// Each round replays addresses 0..limite. Every play is registered and compared, then
// the address or the round limit advances. The game ends as won, lost or timed out.
// Latency: jogada_feita at edge N -> registraR in cycle N+1 -> compare decision in
// cycle N+2 -> counter update in cycle N+3. Plays that arrive outside ESPERA are dropped.
// Optional feature: define TIMEOUT_EN to honour the timeout input in ESPERA.
// Without it, timeout is ignored, FIM_TIMEOUT cannot be reached and fim_timeout is 0.
// Ports:
//   clock, reset (async active-low)         : clocking / reset to INICIAL
//   iniciar                                 : start / restart request (level)
//   jogada_feita                            : one-cycle play pulse
//   chavesIgualMemoria, enderecoIgualLimite : datapath compare results
//   limite[3:0]                             : current round limit
//   timeout                                 : datapath inactivity timeout
//   zeraE/contaE, zeraL/contaL, zeraR/registraR : counter and register controls
//   pronto, acertou, errou, fim_timeout     : end-of-game flags
//   db_estado[4:0]                          : state code for the debug display
module unidade_controle_jogadas #(
    parameter logic [3:0] LIMITE_FINAL = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualLimite,
    input  logic [3:0] limite,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       fim_timeout,
    output logic [4:0] db_estado
);

    typedef enum logic [4:0] {
        INICIAL     = 5'h00,
        PREPARA     = 5'h01,
        INICIA_SEQ  = 5'h02,
        ESPERA      = 5'h03,
        REGISTRA    = 5'h04,
        COMPARA     = 5'h05,
        PROX_JOGADA = 5'h06,
        PROX_SEQ    = 5'h07,
        FIM_ACERTOU = 5'h0A,
        FIM_TIMEOUT = 5'h0D,
        FIM_ERROU   = 5'h0E
    } estado_t;

    estado_t r_estado;
    estado_t w_prox;
    logic    w_timeout;

    logic r_zeraE, r_contaE, r_zeraL, r_contaL, r_zeraR, r_registraR;
    logic r_pronto, r_acertou, r_errou, r_fim_timeout;

`ifdef TIMEOUT_EN
    assign w_timeout   = timeout;
    assign fim_timeout = r_fim_timeout;
`else
    assign w_timeout   = 1'b0;
    assign fim_timeout = 1'b0;
    logic  w_unused_timeout;
    logic  w_unused_fim;
    assign w_unused_timeout = timeout;
    assign w_unused_fim     = r_fim_timeout;
`endif

    // Next-state decode. A play in ESPERA takes priority over a timeout in the same cycle.
    always_comb begin
        w_prox = INICIAL;
        case (r_estado)
            INICIAL:     w_prox = iniciar ? PREPARA : INICIAL;
            PREPARA:     w_prox = INICIA_SEQ;
            INICIA_SEQ:  w_prox = ESPERA;
            ESPERA: begin
                if (jogada_feita)   w_prox = REGISTRA;
                else if (w_timeout) w_prox = FIM_TIMEOUT;
                else                w_prox = ESPERA;
            end
            REGISTRA:    w_prox = COMPARA;
            COMPARA: begin
                if (!chavesIgualMemoria)
                    w_prox = FIM_ERROU;
                else if (enderecoIgualLimite && (limite == LIMITE_FINAL))
                    w_prox = FIM_ACERTOU;
                else if (enderecoIgualLimite)
                    w_prox = PROX_SEQ;
                else
                    w_prox = PROX_JOGADA;
            end
            PROX_JOGADA: w_prox = ESPERA;
            PROX_SEQ:    w_prox = INICIA_SEQ;
            FIM_ACERTOU: w_prox = iniciar ? PREPARA : FIM_ACERTOU;
            FIM_ERROU:   w_prox = iniciar ? PREPARA : FIM_ERROU;
            FIM_TIMEOUT: w_prox = iniciar ? PREPARA : FIM_TIMEOUT;
            default:     w_prox = INICIAL;
        endcase
    end

    // State and outputs share one register stage: outputs are decoded from the next
    // state so they line up with the state they belong to, without combinational glitches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado      <= INICIAL;
            r_zeraE       <= 1'b0;
            r_contaE      <= 1'b0;
            r_zeraL       <= 1'b0;
            r_contaL      <= 1'b0;
            r_zeraR       <= 1'b0;
            r_registraR   <= 1'b0;
            r_pronto      <= 1'b0;
            r_acertou     <= 1'b0;
            r_errou       <= 1'b0;
            r_fim_timeout <= 1'b0;
        end else begin
            r_estado      <= w_prox;
            // zeraE on each new round also restarts the datapath timeout counter.
            r_zeraE       <= (w_prox == PREPARA) || (w_prox == INICIA_SEQ);
            r_contaE      <= (w_prox == PROX_JOGADA);
            r_zeraL       <= (w_prox == PREPARA);
            r_contaL      <= (w_prox == PROX_SEQ);
            r_zeraR       <= (w_prox == PREPARA);
            r_registraR   <= (w_prox == REGISTRA);
            r_pronto      <= (w_prox == FIM_ACERTOU) || (w_prox == FIM_ERROU) ||
                             (w_prox == FIM_TIMEOUT);
            r_acertou     <= (w_prox == FIM_ACERTOU);
            r_errou       <= (w_prox == FIM_ERROU);
            r_fim_timeout <= (w_prox == FIM_TIMEOUT);
        end
    end

    assign zeraE     = r_zeraE;
    assign contaE    = r_contaE;
    assign zeraL     = r_zeraL;
    assign contaL    = r_contaL;
    assign zeraR     = r_zeraR;
    assign registraR = r_registraR;
    assign pronto    = r_pronto;
    assign acertou   = r_acertou;
    assign errou     = r_errou;
    assign db_estado = r_estado;

endmodule
